// File: rtl/pc_trace_monitor_pkg.sv
// Shared types for the PC trace monitor: FSM states, run status codes and
// the width helper used for the watchpoint index.
package pc_trace_monitor_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_END     = 2'b01,
      ST_TIMEOUT = 2'b10,
      ST_HANG    = 2'b11
   } status_t;

   // A single watchpoint still needs a 1-bit index port.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pc_trace_monitor_if.sv
// Bundle between the core/bench side (master) and the trace monitor (slave):
// run control, sampled core state, watchpoint/end configuration and results.
interface pc_trace_monitor_if #(
   parameter int unsigned PC_W      = 16,
   parameter int unsigned INSTR_W   = 32,
   parameter int unsigned NUM_WATCH = 4,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned IDX_W     = pc_trace_monitor_pkg::idx_width(NUM_WATCH)
);
   logic                        enable;
   logic                        restart;
   logic [PC_W-1:0]             pc;
   logic [INSTR_W-1:0]          instruction;
   logic                        branch_sig;
   logic [NUM_WATCH*PC_W-1:0]   watch_pc;
   logic [NUM_WATCH-1:0]        watch_en;
   logic [PC_W-1:0]             end_pc;
   logic [CNT_W-1:0]            max_cycles;
   logic                        hit_valid;
   logic [IDX_W-1:0]            hit_index;
   logic [INSTR_W-1:0]          hit_instr;
   logic [CNT_W-1:0]            retired_cnt;
   logic [CNT_W-1:0]            taken_cnt;
   logic                        done;
   logic [1:0]                  status;

   modport master (
      output enable, restart, pc, instruction, branch_sig,
             watch_pc, watch_en, end_pc, max_cycles,
      input  hit_valid, hit_index, hit_instr, retired_cnt, taken_cnt, done, status
   );

   modport slave (
      input  enable, restart, pc, instruction, branch_sig,
             watch_pc, watch_en, end_pc, max_cycles,
      output hit_valid, hit_index, hit_instr, retired_cnt, taken_cnt, done, status
   );
endinterface

// File: rtl/pc_trace_monitor_watch.sv
// Watchpoint comparators with lowest-index-wins priority encoding.
module pc_watch_match #(
   parameter int unsigned PC_W      = 16,
   parameter int unsigned NUM_WATCH = 4,
   parameter int unsigned IDX_W     = 2
) (
   input  logic [PC_W-1:0]           pc,
   input  logic [NUM_WATCH*PC_W-1:0] watch_pc,
   input  logic [NUM_WATCH-1:0]      watch_en,
   output logic                      match,
   output logic [IDX_W-1:0]          match_index
);

   // Scan from the top so the lowest matching entry is written last.
   always_comb begin
      match       = 1'b0;
      match_index = '0;
      for (int unsigned i = NUM_WATCH; i > 0; i--) begin
         if (watch_en[i-1] && (pc == watch_pc[(i-1)*PC_W +: PC_W])) begin
            match       = 1'b1;
            match_index = IDX_W'(i - 1);
         end
      end
   end

endmodule

// File: rtl/pc_trace_monitor.sv
// Run monitor beside a mips16bits-family core: counts retired and taken
// instructions, reports watchpoint hits and ends the run on end-PC/hang/timeout.
module pc_trace_monitor
   import pc_trace_monitor_pkg::*;
#(
   parameter int unsigned PC_W        = 16,
   parameter int unsigned INSTR_W     = 32,
   parameter int unsigned NUM_WATCH   = 4,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned STALL_LIMIT = 8,
   parameter int unsigned PC_STEP     = 1
) (
   input logic                clock,
   input logic                reset_n,
   pc_trace_monitor_if.slave  mon
);

   localparam int unsigned IDX_W = idx_width(NUM_WATCH);
   localparam int unsigned SW    = $clog2(STALL_LIMIT + 1);

   state_t               state, state_next;
   status_t              status_q, end_status;
   logic [PC_W-1:0]      prev_pc;
   logic                 prev_branch, prev_valid;
   logic [SW-1:0]        stall_cnt, stall_next;
   logic [CNT_W-1:0]     retired_q, taken_q;
   logic                 hit_valid_q, done_q;
   logic [IDX_W-1:0]     hit_index_q;
   logic [INSTR_W-1:0]   hit_instr_q;
   logic                 sample, end_run, end_hit, hang_hit, timeout_hit, is_taken;
   logic                 match;
   logic [IDX_W-1:0]     match_index;

   pc_watch_match #(.PC_W(PC_W), .NUM_WATCH(NUM_WATCH), .IDX_W(IDX_W)) u_match (
      .pc          (mon.pc),
      .watch_pc    (mon.watch_pc),
      .watch_en    (mon.watch_en),
      .match       (match),
      .match_index (match_index)
   );

   assign sample      = (state == S_RUN) && mon.enable;
   assign stall_next  = (prev_valid && (mon.pc == prev_pc)) ? stall_cnt + SW'(1) : SW'(1);
   // Widened sum so a wrap from all-ones to zero is seen as non-sequential.
   assign is_taken    = prev_valid && prev_branch &&
                        ((PC_W+1)'(mon.pc) != ((PC_W+1)'(prev_pc) + (PC_W+1)'(PC_STEP)));
   assign end_hit     = mon.pc >= mon.end_pc;
   assign hang_hit    = stall_next == SW'(STALL_LIMIT);
   assign timeout_hit = (mon.max_cycles != '0) &&
                        (((CNT_W+1)'(retired_q) + (CNT_W+1)'(1)) == (CNT_W+1)'(mon.max_cycles));

   always_comb begin
      end_run    = 1'b0;
      end_status = ST_RUN;
      if (end_hit) begin
         end_run    = 1'b1;
         end_status = ST_END;
      end else if (hang_hit) begin
         end_run    = 1'b1;
         end_status = ST_HANG;
      end else if (timeout_hit) begin
         end_run    = 1'b1;
         end_status = ST_TIMEOUT;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:  if (mon.enable) state_next = S_RUN;
         S_RUN:   if (!mon.enable) state_next = S_PAUSE;
                  else if (end_run) state_next = S_DONE;
         S_PAUSE: if (mon.enable) state_next = S_RUN;
         S_DONE:  state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
      if (mon.restart) state_next = S_IDLE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prev_pc     <= '0;
         prev_branch <= 1'b0;
         prev_valid  <= 1'b0;
         stall_cnt   <= '0;
         retired_q   <= '0;
         taken_q     <= '0;
         hit_valid_q <= 1'b0;
         hit_index_q <= '0;
         hit_instr_q <= '0;
         done_q      <= 1'b0;
         status_q    <= ST_RUN;
      end else if (mon.restart) begin
         prev_pc     <= '0;
         prev_branch <= 1'b0;
         prev_valid  <= 1'b0;
         stall_cnt   <= '0;
         retired_q   <= '0;
         taken_q     <= '0;
         hit_valid_q <= 1'b0;
         hit_index_q <= '0;
         hit_instr_q <= '0;
         done_q      <= 1'b0;
         status_q    <= ST_RUN;
      end else begin
         hit_valid_q <= 1'b0;
         if (sample) begin
            prev_pc     <= mon.pc;
            prev_branch <= mon.branch_sig;
            prev_valid  <= 1'b1;
            stall_cnt   <= stall_next;
            if (retired_q != '1) retired_q <= retired_q + CNT_W'(1);
            if (is_taken && (taken_q != '1)) taken_q <= taken_q + CNT_W'(1);
            if (match) begin
               hit_valid_q <= 1'b1;
               hit_index_q <= match_index;
               hit_instr_q <= mon.instruction;
            end
            if (end_run) begin
               done_q   <= 1'b1;
               status_q <= end_status;
            end
         end
      end
   end

   assign mon.hit_valid   = hit_valid_q;
   assign mon.hit_index   = hit_index_q;
   assign mon.hit_instr   = hit_instr_q;
   assign mon.retired_cnt = retired_q;
   assign mon.taken_cnt   = taken_q;
   assign mon.done        = done_q;
   assign mon.status      = status_q;

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Bench for pc_trace_monitor: sample-history reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_pc_trace_monitor;

   localparam int unsigned PC_W    = 16;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned NW      = 4;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned STALL   = 8;
   localparam int unsigned STEP    = 1;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   pc_trace_monitor_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NUM_WATCH(NW), .CNT_W(CNT_W)) bus ();
   pc_trace_monitor_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NUM_WATCH(NW), .CNT_W(4)) bus4 ();

   pc_trace_monitor #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NUM_WATCH(NW), .CNT_W(CNT_W),
                      .STALL_LIMIT(STALL), .PC_STEP(STEP)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .mon     (bus.slave)
   );

   pc_trace_monitor #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NUM_WATCH(NW), .CNT_W(4),
                      .STALL_LIMIT(STALL), .PC_STEP(STEP)) dut4 (
      .clock   (clock),
      .reset_n (reset_n),
      .mon     (bus4.slave)
   );

   assign bus4.enable      = bus.enable;
   assign bus4.restart     = bus.restart;
   assign bus4.pc          = bus.pc;
   assign bus4.instruction = bus.instruction;
   assign bus4.branch_sig  = bus.branch_sig;
   assign bus4.watch_pc    = '0;
   assign bus4.watch_en    = '0;
   assign bus4.end_pc      = '1;
   assign bus4.max_cycles  = '0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: keeps the full history of sampled PCs/branches of the run.
   typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mmode_t;
   mmode_t    m_mode = M_IDLE;
   int        m_samples = 0;
   int        m_taken   = 0;
   int        q_pc[$];
   bit        q_br[$];
   bit        m_hv = 0;
   int        m_hidx = 0;
   bit [31:0] m_hins = '0;
   bit        m_done = 0;
   int        m_status = 0;

   function automatic void model_clear();
      m_mode = M_IDLE; m_samples = 0; m_taken = 0;
      q_pc.delete(); q_br.delete();
      m_hv = 0; m_hidx = 0; m_hins = '0; m_done = 0; m_status = 0;
   endfunction

   function automatic void model_sample();
      int cur;
      int run_len;
      bit at_end, hang, tmo;
      cur = int'(bus.pc);
      m_samples++;
      if (q_pc.size() > 0 && q_br[$] && cur != q_pc[$] + int'(STEP)) m_taken++;
      q_pc.push_back(cur);
      q_br.push_back(bus.branch_sig);
      run_len = 1;
      for (int k = q_pc.size() - 2; k >= 0; k--) begin
         if (q_pc[k] != cur) break;
         run_len++;
      end
      for (int i = 0; i < int'(NW); i++) begin
         if (bus.watch_en[i] && int'(bus.watch_pc[i*PC_W +: PC_W]) == cur) begin
            m_hv = 1; m_hidx = i; m_hins = bus.instruction;
            break;
         end
      end
      at_end = cur >= int'(bus.end_pc);
      hang   = run_len >= int'(STALL);
      tmo    = (bus.max_cycles != 0) && (m_samples == int'(bus.max_cycles));
      if (at_end || hang || tmo) begin
         m_mode = M_DONE;
         m_done = 1;
         m_status = at_end ? 1 : (hang ? 3 : 2);
      end
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n || bus.restart) model_clear();
      else begin
         m_hv = 0;
         case (m_mode)
            M_IDLE, M_PAUSE: if (bus.enable) m_mode = M_RUN;
            M_RUN:           if (!bus.enable) m_mode = M_PAUSE; else model_sample();
            default: ;
         endcase
      end
   end

   always @(negedge clock) begin
      check("retired_cnt", 64'(bus.retired_cnt), 64'((m_samples > CNT_MAX) ? CNT_MAX : m_samples));
      check("taken_cnt",   64'(bus.taken_cnt),   64'((m_taken > CNT_MAX) ? CNT_MAX : m_taken));
      check("hit_valid",   64'(bus.hit_valid),   64'(m_hv));
      check("hit_index",   64'(bus.hit_index),   64'(m_hidx));
      check("hit_instr",   64'(bus.hit_instr),   64'(m_hins));
      check("done",        64'(bus.done),        64'(m_done));
      check("status",      64'(bus.status),      64'(m_status));
   end

   function automatic logic [INSTR_W-1:0] instr_of(input int p);
      logic [PC_W-1:0] lo;
      lo = PC_W'(p);
      return {16'hC0DE, lo};
   endfunction

   task automatic cyc(input int p, input bit br);
      bus.pc          = PC_W'(p);
      bus.instruction = instr_of(p);
      bus.branch_sig  = br;
      @(posedge clock);
      #2;
   endtask

   task automatic do_restart();
      bus.restart = 1'b1;
      cyc(0, 0);
      bus.restart = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.enable = 1'b0; bus.restart = 1'b0; bus.pc = '0; bus.instruction = '0;
      bus.branch_sig = 1'b0; bus.watch_pc = '0; bus.watch_en = '0;
      bus.end_pc = '1; bus.max_cycles = '0;
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1;

      // Reset in the middle of a run, then re-enable.
      bus.enable = 1'b1;
      cyc(0, 0);
      for (int p = 0; p <= 4; p++) cyc(p, 0);
      check("retired_before_reset", 64'(bus.retired_cnt), 64'd5);
      #1 reset_n = 1'b0;
      #1;
      check("rst_retired", 64'(bus.retired_cnt), 64'd0);
      check("rst_taken",   64'(bus.taken_cnt),   64'd0);
      check("rst_done",    64'(bus.done),        64'd0);
      check("rst_status",  64'(bus.status),      64'd0);
      check("rst_hit_valid", 64'(bus.hit_valid), 64'd0);
      check("rst_hit_instr", 64'(bus.hit_instr), 64'd0);
      #2 reset_n = 1'b1;
      cyc(0, 0);
      cyc(1, 0);
      check("retired_after_reenable", 64'(bus.retired_cnt), 64'd1);

      // end_pc reached, with two enabled watchpoints on the same address.
      bus.end_pc = 16'd10;
      bus.watch_pc[2*PC_W +: PC_W] = 16'd10;
      bus.watch_pc[0 +: PC_W]      = 16'd10;
      bus.watch_en = 4'b0101;
      do_restart();
      cyc(0, 0);
      for (int p = 0; p <= 9; p++) cyc(p, 0);
      check("end_not_yet", 64'(bus.done), 64'd0);
      cyc(10, 0);
      check("end_done",      64'(bus.done),        64'd1);
      check("end_status",    64'(bus.status),      64'd1);
      check("end_retired",   64'(bus.retired_cnt), 64'd11);
      check("end_hit_valid", 64'(bus.hit_valid),   64'd1);
      check("end_hit_index", 64'(bus.hit_index),   64'd0);
      check("end_hit_instr", 64'(bus.hit_instr),   64'hC0DE000A);
      cyc(11, 0);
      check("hit_pulse_ends", 64'(bus.hit_valid),  64'd0);
      check("done_sticky",    64'(bus.done),       64'd1);
      check("hit_instr_held", 64'(bus.hit_instr),  64'hC0DE000A);

      // Taken/not-taken branches and a pause in the middle.
      bus.end_pc = '1; bus.watch_en = '0;
      do_restart();
      cyc(3, 0);
      cyc(3, 0);
      cyc(4, 1);
      cyc(7, 0);
      check("taken_jump", 64'(bus.taken_cnt), 64'd1);
      cyc(5, 1);
      cyc(6, 0);
      check("taken_seq_unchanged", 64'(bus.taken_cnt), 64'd1);
      bus.enable = 1'b0;
      cyc(6, 0);
      cyc(6, 0);
      check("pause_holds", 64'(bus.retired_cnt), 64'd5);
      bus.enable = 1'b1;
      cyc(7, 0);
      cyc(8, 0);
      check("resume_counts", 64'(bus.retired_cnt), 64'd6);

      // Hang at pc=3 with a watchpoint re-firing on every stalled sample.
      bus.watch_pc = '0;
      bus.watch_pc[1*PC_W +: PC_W] = 16'd3;
      bus.watch_en = 4'b0010;
      do_restart();
      cyc(3, 0);
      for (int n = 0; n < 7; n++) cyc(3, 0);
      check("hang_not_yet",   64'(bus.done),      64'd0);
      check("stall_hit_valid", 64'(bus.hit_valid), 64'd1);
      check("stall_hit_index", 64'(bus.hit_index), 64'd1);
      cyc(3, 0);
      check("hang_done",   64'(bus.done),        64'd1);
      check("hang_status", 64'(bus.status),      64'd3);
      check("hang_retired", 64'(bus.retired_cnt), 64'd8);

      // Timeout after 20 samples on a free-running pc.
      bus.watch_en = '0; bus.max_cycles = 16'd20;
      do_restart();
      cyc(100, 0);
      for (int p = 100; p <= 118; p++) cyc(p, 0);
      check("timeout_not_yet", 64'(bus.done), 64'd0);
      cyc(119, 0);
      check("timeout_status",  64'(bus.status),      64'd2);
      check("timeout_retired", 64'(bus.retired_cnt), 64'd20);

      // end_pc and timeout on the same sample: end_pc wins.
      bus.max_cycles = 16'd3; bus.end_pc = 16'd2;
      do_restart();
      cyc(0, 0);
      for (int p = 0; p <= 2; p++) cyc(p, 0);
      check("prio_status", 64'(bus.status), 64'd1);

      // Saturation of the narrow-counter instance, then restart.
      bus.max_cycles = '0; bus.end_pc = '1;
      do_restart();
      cyc(0, 0);
      for (int p = 0; p <= 19; p++) cyc(p, 0);
      check("sat_retired4", 64'(bus4.retired_cnt), 64'd15);
      check("wide_retired", 64'(bus.retired_cnt),  64'd20);
      do_restart();
      check("restart_retired4", 64'(bus4.retired_cnt), 64'd0);
      check("restart_done4",    64'(bus4.done),        64'd0);
      check("restart_status4",  64'(bus4.status),      64'd0);

      repeat (2) @(posedge clock);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
